// File: rtl/rs_logical.sv
// rs_logical: reservation station feeding the logical functional unit.
// Buffers renamed instructions, captures operands from the writeback bus and
// launches ready entries into a registered issue slot.
//
// Ports:
//   clk, rst (sync, active-high), flush  - clock / reset / mispredict discard
//   in_valid/in_ready, in_inst, in_inst_id, in_op_prn, in_op_rdy, in_op_val,
//   in_out_prn                           - dispatch (allocation) interface
//   wb_valid, wb_prn, wb_data            - writeback broadcast ports
//   iss_valid, iss_inst, iss_inst_id, iss_op, iss_out_prn, fu_ready
//                                        - issue slot towards the FU
//   count                                - occupied entries
//
// Build option: define RS_LOGICAL_AGE_ORDER_EN to select the oldest eligible
// entry via an age matrix; otherwise the lowest-index eligible entry wins.

module rs_logical #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PRN_W    = 7,
  parameter int unsigned ID_W     = 6,
  parameter int unsigned WB_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [ID_W-1:0]            in_inst_id,
  input  logic [3*PRN_W-1:0]         in_op_prn,
  input  logic [2:0]                 in_op_rdy,
  input  logic [3*64-1:0]            in_op_val,
  input  logic [3*PRN_W-1:0]         in_out_prn,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*PRN_W-1:0]  wb_prn,
  input  logic [WB_PORTS*64-1:0]     wb_data,
  output logic                       iss_valid,
  output logic [31:0]                iss_inst,
  output logic [ID_W-1:0]            iss_inst_id,
  output logic [3*64-1:0]            iss_op,
  output logic [3*PRN_W-1:0]         iss_out_prn,
  input  logic                       fu_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [31:0]        inst_q [DEPTH];
  logic [31:0]        inst_d [DEPTH];
  logic [ID_W-1:0]    id_q   [DEPTH];
  logic [ID_W-1:0]    id_d   [DEPTH];
  logic [3*PRN_W-1:0] prn_q  [DEPTH];
  logic [3*PRN_W-1:0] prn_d  [DEPTH];
  logic [2:0]         rdy_q  [DEPTH];
  logic [2:0]         rdy_d  [DEPTH];
  logic [3*64-1:0]    val_q  [DEPTH];
  logic [3*64-1:0]    val_d  [DEPTH];
  logic [3*PRN_W-1:0] outp_q [DEPTH];
  logic [3*PRN_W-1:0] outp_d [DEPTH];

  logic               iss_valid_q, iss_valid_d;
  logic [31:0]        iss_inst_q, iss_inst_d;
  logic [ID_W-1:0]    iss_id_q, iss_id_d;
  logic [3*64-1:0]    iss_op_q, iss_op_d;
  logic [3*PRN_W-1:0] iss_outp_q, iss_outp_d;
  logic [CntW-1:0]    count_q, count_d;

  logic [DEPTH-1:0] eligible;
  logic [IdxW-1:0]  sel_idx, alloc_idx;
  logic             sel_found, launch, alloc;

  assign in_ready = (count_q < CntW'(DEPTH));
  assign alloc    = in_valid && in_ready && !flush;
  assign launch   = (!iss_valid_q || fu_ready) && sel_found && !flush;

  // Eligibility uses registered rdy only, so a same-cycle wakeup waits a cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      eligible[i] = valid_q[i] && (&rdy_q[i]);
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IdxW'(i);
    end
  end

`ifdef RS_LOGICAL_AGE_ORDER_EN
  // age_q[i][j] set: entry i is older than entry j.
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic             older_found;

  always_comb begin
    sel_found   = 1'b0;
    sel_idx     = '0;
    older_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      older_found = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (eligible[j] && age_q[j][i]) older_found = 1'b1;
      end
      if (eligible[i] && !older_found && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    age_d = age_q;
    if (alloc) begin
      for (int j = 0; j < DEPTH; j++) begin
        age_d[alloc_idx][j] = 1'b0;
        age_d[j][alloc_idx] = (j != int'(alloc_idx));
      end
    end
  end

  always_ff @(posedge clk) begin
    age_q <= age_d;
  end
`else
  always_comb begin
    sel_found = |eligible;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) sel_idx = IdxW'(i);
    end
  end
`endif

  always_comb begin
    valid_d     = valid_q;
    inst_d      = inst_q;
    id_d        = id_q;
    prn_d       = prn_q;
    rdy_d       = rdy_q;
    val_d       = val_q;
    outp_d      = outp_q;
    iss_valid_d = iss_valid_q;
    iss_inst_d  = iss_inst_q;
    iss_id_d    = iss_id_q;
    iss_op_d    = iss_op_q;
    iss_outp_d  = iss_outp_q;
    count_d     = count_q + CntW'(alloc) - CntW'(launch);

    // Wakeup: descending port scan so the lowest matching port wins.
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (valid_q[i] && !rdy_q[i][k]) begin
          for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (wb_valid[p] && (wb_prn[p*PRN_W +: PRN_W] == prn_q[i][k*PRN_W +: PRN_W])) begin
              rdy_d[i][k]        = 1'b1;
              val_d[i][k*64 +: 64] = wb_data[p*64 +: 64];
            end
          end
        end
      end
    end

    if (launch) begin
      valid_d[sel_idx] = 1'b0;
      iss_valid_d      = 1'b1;
      iss_inst_d       = inst_q[sel_idx];
      iss_id_d         = id_q[sel_idx];
      iss_op_d         = val_q[sel_idx];
      iss_outp_d       = outp_q[sel_idx];
    end else if (fu_ready) begin
      iss_valid_d = 1'b0;
    end

    if (alloc) begin
      valid_d[alloc_idx] = 1'b1;
      inst_d[alloc_idx]  = in_inst;
      id_d[alloc_idx]    = in_inst_id;
      prn_d[alloc_idx]   = in_op_prn;
      outp_d[alloc_idx]  = in_out_prn;
      rdy_d[alloc_idx]   = in_op_rdy;
      val_d[alloc_idx]   = in_op_val;
      for (int k = 0; k < 3; k++) begin
        if (!in_op_rdy[k]) begin
          for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (wb_valid[p] && (wb_prn[p*PRN_W +: PRN_W] == in_op_prn[k*PRN_W +: PRN_W])) begin
              rdy_d[alloc_idx][k]          = 1'b1;
              val_d[alloc_idx][k*64 +: 64] = wb_data[p*64 +: 64];
            end
          end
        end
      end
    end

    if (flush) begin
      valid_d     = '0;
      iss_valid_d = 1'b0;
      iss_inst_d  = '0;
      iss_id_d    = '0;
      iss_op_d    = '0;
      iss_outp_d  = '0;
      count_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_inst_q  <= '0;
      iss_id_q    <= '0;
      iss_op_q    <= '0;
      iss_outp_q  <= '0;
      count_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      iss_valid_q <= iss_valid_d;
      iss_inst_q  <= iss_inst_d;
      iss_id_q    <= iss_id_d;
      iss_op_q    <= iss_op_d;
      iss_outp_q  <= iss_outp_d;
      count_q     <= count_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    inst_q <= inst_d;
    id_q   <= id_d;
    prn_q  <= prn_d;
    rdy_q  <= rdy_d;
    val_q  <= val_d;
    outp_q <= outp_d;
  end

  assign iss_valid   = iss_valid_q;
  assign iss_inst    = iss_inst_q;
  assign iss_inst_id = iss_id_q;
  assign iss_op      = iss_op_q;
  assign iss_out_prn = iss_outp_q;
  assign count       = count_q;

endmodule

// File: tb/tb_rs_logical.sv
// Directed testbench for rs_logical (DEPTH=8, PRN_W=7, ID_W=6, WB_PORTS=2).
module tb_rs_logical;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, fu_ready, iss_valid;
  logic [31:0] in_inst, iss_inst;
  logic [5:0]  in_inst_id, iss_inst_id;
  logic [20:0] in_op_prn, in_out_prn, iss_out_prn;
  logic [2:0]  in_op_rdy;
  logic [191:0] in_op_val, iss_op;
  logic [1:0]  wb_valid;
  logic [13:0] wb_prn;
  logic [127:0] wb_data;
  logic [3:0]  count;

  int n_chk  = 0;
  int n_pass = 0;

  rs_logical #(.DEPTH(8), .PRN_W(7), .ID_W(6), .WB_PORTS(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_inst_id(in_inst_id), .in_op_prn(in_op_prn),
    .in_op_rdy(in_op_rdy), .in_op_val(in_op_val), .in_out_prn(in_out_prn),
    .wb_valid(wb_valid), .wb_prn(wb_prn), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_inst(iss_inst), .iss_inst_id(iss_inst_id),
    .iss_op(iss_op), .iss_out_prn(iss_out_prn), .fu_ready(fu_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one dispatch for a single edge.
  task automatic dispatch(input logic [31:0] inst, input logic [5:0] id,
                          input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                          input logic [2:0] rdy, input logic [63:0] v0, input logic [63:0] v1,
                          input logic [63:0] v2);
    in_valid   = 1'b1;
    in_inst    = inst;
    in_inst_id = id;
    in_op_prn  = {p2, p1, p0};
    in_op_rdy  = rdy;
    in_op_val  = {v2, v1, v0};
    in_out_prn = {7'd3, 7'd2, 7'd1};
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [1:0] v, input logic [6:0] p0, input logic [63:0] d0,
                    input logic [6:0] p1, input logic [63:0] d1);
    wb_valid = v;
    wb_prn   = {p1, p0};
    wb_data  = {d1, d0};
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; fu_ready = 1'b1;
    in_inst = '0; in_inst_id = '0; in_op_prn = '0; in_op_rdy = '0; in_op_val = '0;
    in_out_prn = '0; wb_valid = '0; wb_prn = '0; wb_data = '0;
    tick(); tick();
    rst = 1'b0;
    n_chk++; if (iss_valid !== 1'b0) $display("FAIL reset_iss_valid got=%b exp=0", iss_valid); else n_pass++;
    n_chk++; if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_chk++; if (iss_op !== '0 || iss_inst !== '0) $display("FAIL reset_iss_payload got=%h/%h exp=0", iss_op, iss_inst); else n_pass++;
  endtask

  task automatic test_orr();
    dispatch(32'hAA00_0001, 6'd1, 7'd10, 7'd11, 7'd12, 3'b111, 64'hF0, 64'h0F, 64'h0);
    n_chk++; if (count !== 4'd1 || iss_valid !== 1'b0) $display("FAIL orr_alloc got count=%0d iss=%b exp 1/0", count, iss_valid); else n_pass++;
    tick();
    n_chk++; if (iss_valid !== 1'b1) $display("FAIL orr_issue got=%b exp=1", iss_valid); else n_pass++;
    n_chk++; if (iss_op[63:0] !== 64'hF0 || iss_op[127:64] !== 64'h0F) $display("FAIL orr_ops got=%h exp=f0/0f", iss_op[127:0]); else n_pass++;
    n_chk++; if (iss_inst !== 32'hAA00_0001 || iss_out_prn !== {7'd3, 7'd2, 7'd1}) $display("FAIL orr_inst got=%h exp=aa000001", iss_inst); else n_pass++;
    n_chk++; if (count !== 4'd0) $display("FAIL orr_count got=%0d exp=0", count); else n_pass++;
    tick();
    n_chk++; if (iss_valid !== 1'b0) $display("FAIL orr_drain got=%b exp=0", iss_valid); else n_pass++;
  endtask

  task automatic test_wakeup();
    dispatch(32'hCC00_0002, 6'd2, 7'd20, 7'd21, 7'd12, 3'b011, 64'h1, 64'h2, 64'h0);
    wb(2'b10, 7'd99, 64'h77, 7'd12, 64'h4);
    tick();
    wb(2'b00, 7'd0, 64'h0, 7'd0, 64'h0);
    n_chk++; if (iss_valid !== 1'b0) $display("FAIL wake_not_early got=%b exp=0", iss_valid); else n_pass++;
    tick();
    n_chk++; if (iss_valid !== 1'b1 || iss_op[191:128] !== 64'h4) $display("FAIL wake_issue got=%b/%h exp=1/4", iss_valid, iss_op[191:128]); else n_pass++;
    tick();
  endtask

  task automatic test_alloc_capture();
    // Both ports hit PRN 5; port 0 must win.
    wb(2'b11, 7'd5, 64'h55, 7'd5, 64'h66);
    dispatch(32'hDD00_0003, 6'd3, 7'd5, 7'd30, 7'd31, 3'b110, 64'h0, 64'h9, 64'h8);
    wb(2'b00, 7'd0, 64'h0, 7'd0, 64'h0);
    n_chk++; if (iss_valid !== 1'b0 || count !== 4'd1) $display("FAIL cap_alloc got=%b/%0d exp=0/1", iss_valid, count); else n_pass++;
    tick();
    n_chk++; if (iss_valid !== 1'b1 || iss_op[63:0] !== 64'h55) $display("FAIL cap_issue got=%b/%h exp=1/55", iss_valid, iss_op[63:0]); else n_pass++;
    tick();
  endtask

  task automatic test_full_order_hold_flush();
    logic [5:0] first_id, second_id;
    for (int i = 0; i < 8; i++) begin
      dispatch(32'h100 + i, 6'(i), 7'd1, 7'd2, 7'(32 + i), 3'b011, 64'h1, 64'h2, 64'h0);
    end
    n_chk++; if (count !== 4'd8 || in_ready !== 1'b0) $display("FAIL full got count=%0d rdy=%b exp 8/0", count, in_ready); else n_pass++;
    dispatch(32'hDEAD, 6'd63, 7'd1, 7'd2, 7'd3, 3'b111, 64'h0, 64'h0, 64'h0);
    n_chk++; if (count !== 4'd8 || iss_valid !== 1'b0) $display("FAIL full_drop got count=%0d iss=%b exp 8/0", count, iss_valid); else n_pass++;
    // Wake entries 6 and 2 together; entry 2 is both older and lower index.
    wb(2'b11, 7'd38, 64'h66, 7'd34, 64'h22);
    tick();
    wb(2'b00, 7'd0, 64'h0, 7'd0, 64'h0);
    in_valid = 1'b1; in_inst = 32'hBEEF; in_inst_id = 6'd40; in_op_rdy = 3'b011;
    in_op_prn = {7'd60, 7'd2, 7'd1};
    tick();  // launch while full: allocation must not happen
    in_valid = 1'b0;
    n_chk++; if (iss_inst_id !== 6'd2 || iss_op[191:128] !== 64'h22) $display("FAIL order1_first got id=%0d exp=2", iss_inst_id); else n_pass++;
    n_chk++; if (count !== 4'd7 || in_ready !== 1'b1) $display("FAIL full_launch_no_alloc got count=%0d exp=7", count); else n_pass++;
    tick();
    n_chk++; if (iss_inst_id !== 6'd6 || count !== 4'd6) $display("FAIL order1_second got id=%0d count=%0d exp 6/6", iss_inst_id, count); else n_pass++;
    tick();
    n_chk++; if (iss_valid !== 1'b0) $display("FAIL order1_drain got=%b exp=0", iss_valid); else n_pass++;
    // Refill: X->slot2 (id10), Y->slot6 (id11); retire X, then Z->slot2 (id12) is younger than Y.
    dispatch(32'h210, 6'd10, 7'd1, 7'd2, 7'd50, 3'b011, 64'h1, 64'h2, 64'h0);
    dispatch(32'h211, 6'd11, 7'd1, 7'd2, 7'd51, 3'b011, 64'h1, 64'h2, 64'h0);
    wb(2'b01, 7'd50, 64'hA0, 7'd0, 64'h0);
    tick();
    wb(2'b00, 7'd0, 64'h0, 7'd0, 64'h0);
    tick();
    n_chk++; if (iss_inst_id !== 6'd10) $display("FAIL refill_x got id=%0d exp=10", iss_inst_id); else n_pass++;
    dispatch(32'h212, 6'd12, 7'd1, 7'd2, 7'd52, 3'b011, 64'h1, 64'h2, 64'h0);
    n_chk++; if (count !== 4'd8 || iss_valid !== 1'b0) $display("FAIL refill_z got count=%0d iss=%b exp 8/0", count, iss_valid); else n_pass++;
    wb(2'b11, 7'd51, 64'hB1, 7'd52, 64'hB2);
    tick();
    wb(2'b00, 7'd0, 64'h0, 7'd0, 64'h0);
`ifdef RS_LOGICAL_AGE_ORDER_EN
    first_id = 6'd11; second_id = 6'd12;
`else
    first_id = 6'd12; second_id = 6'd11;
`endif
    tick();
    n_chk++; if (iss_inst_id !== first_id || count !== 4'd7) $display("FAIL order2_first got id=%0d count=%0d exp %0d/7", iss_inst_id, count, first_id); else n_pass++;
    // Back-pressure: slot holds while the other woken entry waits.
    fu_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++; if (iss_valid !== 1'b1 || iss_inst_id !== first_id || count !== 4'd7) $display("FAIL hold_%0d got iss=%b id=%0d count=%0d exp 1/%0d/7", c, iss_valid, iss_inst_id, count, first_id); else n_pass++;
    end
    fu_ready = 1'b1;
    tick();
    n_chk++; if (iss_inst_id !== second_id || count !== 4'd6) $display("FAIL order2_second got id=%0d count=%0d exp %0d/6", iss_inst_id, count, second_id); else n_pass++;
    // Wake entry 0 so the slot is full with 5 entries left, then flush.
    wb(2'b01, 7'd32, 64'hC0, 7'd0, 64'h0);
    tick();
    wb(2'b00, 7'd0, 64'h0, 7'd0, 64'h0);
    tick();
    n_chk++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd0 || count !== 4'd5) $display("FAIL preflush got iss=%b id=%0d count=%0d exp 1/0/5", iss_valid, iss_inst_id, count); else n_pass++;
    fu_ready = 1'b0;
    flush = 1'b1;
    wb(2'b01, 7'd33, 64'hC1, 7'd0, 64'h0);
    in_valid = 1'b1; in_op_rdy = 3'b111;
    tick();
    flush = 1'b0; in_valid = 1'b0; fu_ready = 1'b1;
    wb(2'b00, 7'd0, 64'h0, 7'd0, 64'h0);
    n_chk++; if (iss_valid !== 1'b0 || count !== 4'd0 || in_ready !== 1'b1) $display("FAIL flush got iss=%b count=%0d rdy=%b exp 0/0/1", iss_valid, count, in_ready); else n_pass++;
    tick(); tick();
    n_chk++; if (iss_valid !== 1'b0 || count !== 4'd0) $display("FAIL flush_wb_dropped got iss=%b count=%0d exp 0/0", iss_valid, count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    dispatch(32'h301, 6'd21, 7'd1, 7'd2, 7'd3, 3'b111, 64'h11, 64'h0, 64'h0);
    dispatch(32'h302, 6'd22, 7'd1, 7'd2, 7'd3, 3'b111, 64'h22, 64'h0, 64'h0);
    n_chk++; if (iss_inst_id !== 6'd21 || count !== 4'd1) $display("FAIL b2b_a got id=%0d count=%0d exp 21/1", iss_inst_id, count); else n_pass++;
    dispatch(32'h303, 6'd23, 7'd1, 7'd2, 7'd3, 3'b111, 64'h33, 64'h0, 64'h0);
    n_chk++; if (iss_inst_id !== 6'd22 || iss_op[63:0] !== 64'h22) $display("FAIL b2b_b got id=%0d exp 22", iss_inst_id); else n_pass++;
    tick();
    n_chk++; if (iss_inst_id !== 6'd23 || count !== 4'd0 || iss_valid !== 1'b1) $display("FAIL b2b_c got id=%0d count=%0d exp 23/0", iss_inst_id, count); else n_pass++;
    tick();
    n_chk++; if (iss_valid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", iss_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_orr();
    test_wakeup();
    test_alloc_capture();
    test_full_order_hold_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
